mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the width of the write-back data.
REQ-002 The block SHALL have parameter ADDR_W, default 5, giving the width of the register address.
REQ-003 The block SHALL have parameter ZERO_SUPPRESS, default 1; when set to 1, writes to register 0 are dropped.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port flush, input, 1 bit: discards all held entries.
REQ-007 Port in_valid, input, 1 bit: the upstream MEM stage offers an entry.
REQ-008 Port in_ready, output, 1 bit: the stage can accept an entry.
REQ-009 Port in_RegWrite, input, 1 bit: register write enable.
REQ-010 Port in_WriteAddr, input, ADDR_W bits: destination register.
REQ-011 Port in_MEMOut, input, DATA_W bits: write-back data.
REQ-012 Port out_valid, output, 1 bit: the WB side holds an entry.
REQ-013 Port out_ready, input, 1 bit: the register file consumes the entry.
REQ-014 Port out_RegWrite, output, 1 bit; port out_WriteAddr, output, ADDR_W bits; port out_MEMOut, output, DATA_W bits: head-entry payload.
REQ-015 Port fwd_valid, output, 1 bit: equals out_valid AND out_RegWrite, for the forwarding/hazard unit.
REQ-016 Port occupancy, output, 2 bits: number of held entries (0..2).

Function
REQ-017 Storage SHALL be a 2-entry in-order buffer: a head entry and a skid entry.
REQ-018 States SHALL be EMPTY, ONE and TWO; occupancy SHALL be 0, 1 or 2 respectively.
REQ-019 Accept SHALL occur when in_valid=1 and in_ready=1; pop SHALL occur when out_valid=1 and out_ready=1.
REQ-020 in_ready SHALL be registered and SHALL be 1 exactly when the state is not TWO.
REQ-021 out_valid SHALL be 1 exactly when the state is not EMPTY; the out_* outputs SHALL drive the head entry.
REQ-022 EMPTY transitions: accept -> ONE, with the entry written to head; otherwise stay EMPTY.
REQ-023 ONE transitions:
 - accept and no pop -> TWO, entry written to skid;
 - pop and no accept -> EMPTY;
 - accept and pop -> stay ONE, new entry written to head.
REQ-024 TWO transitions: pop -> ONE, skid moved to head; otherwise stay TWO (no accept is possible).
REQ-025 Latency SHALL be 1 cycle: an entry accepted at edge N is visible on out_* after edge N when the buffer was EMPTY.
REQ-026 While out_valid=1 and out_ready=0, all out_* outputs SHALL hold stable.
REQ-027 Entries SHALL leave in acceptance order; none SHALL be duplicated or dropped, except by flush.
REQ-028 With ZERO_SUPPRESS=1, an entry whose WriteAddr equals 0 SHALL be stored with RegWrite=0; address and data SHALL be stored unchanged.
REQ-029 flush=1 SHALL set the state to EMPTY at the next edge, taking priority over a simultaneous accept and pop.
REQ-030 An entry offered in a flush cycle SHALL be discarded, even though the handshake completes.
REQ-031 Stored payload registers SHALL only update on accept or skid-to-head move, never on pop alone.

Reset
REQ-032 While rst=0, the state SHALL be EMPTY and the outputs SHALL be: out_valid=0, fwd_valid=0, occupancy=0, out_RegWrite=0, out_WriteAddr=0, out_MEMOut=0.
REQ-033 While rst=0, in_ready SHALL be 0; it SHALL be 1 from the first edge after rst returns to 1.
REQ-034 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.

Structure
REQ-035 State encoding and the default widths (DATA_W=32, ADDR_W=5) SHALL live in shared package pipe_pkg.
REQ-036 A single module SHALL be used; no sub-module is required.

Verification
REQ-037 Reset, then accept (RegWrite=1, WriteAddr=5, MEMOut=0xDEADBEEF) -> next cycle out_valid=1, fwd_valid=1, occupancy=1, payload matches.
REQ-038 out_ready=0 with 3 offers (A,B,C) -> A and B are accepted, occupancy=2, in_ready=0, C is held off; then out_ready=1 -> A, B, C appear in order.
REQ-039 Steady state with in_valid=1 and out_ready=1 every cycle for 10 cycles -> 10 entries out, occupancy stays 1.
REQ-040 Accept with WriteAddr=0, RegWrite=1 -> out_RegWrite=0, fwd_valid=0; with ZERO_SUPPRESS=0 -> out_RegWrite=1.
REQ-041 occupancy=2, flush together with in_valid=1 -> next cycle occupancy=0, out_valid=0, the offered entry is lost.
REQ-042 rst=0 asserted mid-transfer while occupancy=2 -> out_valid=0 and occupancy=0 immediately, without a clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: MEM/WB buffer state encoding and default datapath widths.
package pipe_pkg;
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } wb_state_e;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
endpackage

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register built as a 2-entry in-order skid buffer with a
// registered in_ready, register-0 write suppression and flush.
module mem_wb_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int ZERO_SUPPRESS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_RegWrite,
  input  logic [ADDR_W-1:0] in_WriteAddr,
  input  logic [DATA_W-1:0] in_MEMOut,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_RegWrite,
  output logic [ADDR_W-1:0] out_WriteAddr,
  output logic [DATA_W-1:0] out_MEMOut,
  output logic              fwd_valid,
  output logic [1:0]        occupancy
);

  wb_state_e         state_q, state_d;
  logic              in_ready_q;
  logic              head_rw, skid_rw;
  logic [ADDR_W-1:0] head_addr, skid_addr;
  logic [DATA_W-1:0] head_data, skid_data;
  logic              accept, pop, in_rw_eff;
  logic              head_we, skid_we, skid_to_head;

  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid & out_ready;

  // Register 0 is hardwired; its writes are neutralised on entry, payload kept.
  assign in_rw_eff = in_RegWrite & ~((ZERO_SUPPRESS != 0) && (in_WriteAddr == '0));

  always_comb begin
    state_d      = state_q;
    head_we      = 1'b0;
    skid_we      = 1'b0;
    skid_to_head = 1'b0;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: if (accept) begin
          state_d = S_ONE;
          head_we = 1'b1;
        end
        S_ONE: begin
          if (accept && !pop) begin
            state_d = S_TWO;
            skid_we = 1'b1;
          end else if (pop && !accept) begin
            state_d = S_EMPTY;
          end else if (accept && pop) begin
            head_we = 1'b1;
          end
        end
        S_TWO: if (pop) begin
          state_d      = S_ONE;
          skid_to_head = 1'b1;
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != S_TWO);
    end
  end

  // Payload moves only on accept or skid promotion; a bare pop leaves it intact.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_rw   <= 1'b0;
      head_addr <= '0;
      head_data <= '0;
      skid_rw   <= 1'b0;
      skid_addr <= '0;
      skid_data <= '0;
    end else begin
      if (head_we) begin
        head_rw   <= in_rw_eff;
        head_addr <= in_WriteAddr;
        head_data <= in_MEMOut;
      end else if (skid_to_head) begin
        head_rw   <= skid_rw;
        head_addr <= skid_addr;
        head_data <= skid_data;
      end
      if (skid_we) begin
        skid_rw   <= in_rw_eff;
        skid_addr <= in_WriteAddr;
        skid_data <= in_MEMOut;
      end
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = (state_q != S_EMPTY);
  assign out_RegWrite  = head_rw;
  assign out_WriteAddr = head_addr;
  assign out_MEMOut    = head_data;
  assign fwd_valid     = out_valid & head_rw;
  assign occupancy     = state_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomised bench for mem_wb_stage against a queue-based model of the buffer.
module tb_mem_wb_stage;
  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0, in_valid = 1'b0, in_RegWrite = 1'b0, out_ready = 1'b0;
  logic [AW-1:0] in_WriteAddr = '0;
  logic [DW-1:0] in_MEMOut = '0;
  logic          in_ready, out_valid, out_RegWrite, fwd_valid;
  logic [AW-1:0] out_WriteAddr;
  logic [DW-1:0] out_MEMOut;
  logic [1:0]    occupancy;
  logic          rdy0, ov0, rw0, fv0;
  logic [AW-1:0] wa0;
  logic [DW-1:0] md0;
  logic [1:0]    occ0;

  mem_wb_stage #(.DATA_W(DW), .ADDR_W(AW), .ZERO_SUPPRESS(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_RegWrite(in_RegWrite), .in_WriteAddr(in_WriteAddr), .in_MEMOut(in_MEMOut),
    .out_valid(out_valid), .out_ready(out_ready), .out_RegWrite(out_RegWrite),
    .out_WriteAddr(out_WriteAddr), .out_MEMOut(out_MEMOut), .fwd_valid(fwd_valid),
    .occupancy(occupancy));

  mem_wb_stage #(.DATA_W(DW), .ADDR_W(AW), .ZERO_SUPPRESS(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
    .in_RegWrite(in_RegWrite), .in_WriteAddr(in_WriteAddr), .in_MEMOut(in_MEMOut),
    .out_valid(ov0), .out_ready(out_ready), .out_RegWrite(rw0),
    .out_WriteAddr(wa0), .out_MEMOut(md0), .fwd_valid(fv0), .occupancy(occ0));

  always #5 clk = ~clk;

  ent_t q[$];
  logic mdl_rdy = 1'b0;
  int   n_chk = 0, n_pass = 0, dut_pops = 0;

  function automatic logic [4:0] exp_status();
    logic nz;
    nz = (q.size() != 0);
    return {nz, 2'(q.size()), mdl_rdy, nz && q[0].rw};
  endfunction

  function automatic logic [DW+AW:0] exp_head();
    return {q[0].rw, q[0].addr, q[0].data};
  endfunction

  // Drive one cycle, advance the model at the edge, leave time at edge+1.
  task automatic cycle(input logic v, input logic rw, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic ordy, input logic fl);
    logic acc, pp;
    ent_t e;
    in_valid = v; in_RegWrite = rw; in_WriteAddr = a; in_MEMOut = d;
    out_ready = ordy; flush = fl;
    if (out_valid && ordy) dut_pops++;
    @(posedge clk);
    acc = v && mdl_rdy;
    pp  = (q.size() != 0) && ordy;
    if (fl) q.delete();
    else begin
      if (pp) void'(q.pop_front());
      if (acc) begin
        e.rw = rw && (a != 0); e.addr = a; e.data = d;
        q.push_back(e);
      end
    end
    mdl_rdy = (q.size() < 2);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    n_chk++;
    if ({out_valid, fwd_valid, occupancy, in_ready, out_RegWrite, out_WriteAddr, out_MEMOut} !== '0)
      $display("FAIL reset_outputs: got v=%b f=%b occ=%0d rdy=%b rw=%b a=%0d d=%h, want all 0",
               out_valid, fwd_valid, occupancy, in_ready, out_RegWrite, out_WriteAddr, out_MEMOut);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1;
    cycle(0, 0, 0, 0, 0, 0);
    n_chk++;
    if ({in_ready, out_valid, occupancy} !== 4'b1000)
      $display("FAIL reset_release: rdy=%b v=%b occ=%0d, want rdy=1 v=0 occ=0",
               in_ready, out_valid, occupancy);
    else n_pass++;
  endtask

  task automatic test_basic();
    cycle(1, 1, 5, 32'hDEADBEEF, 0, 0);
    n_chk++;
    if ({out_valid, fwd_valid, occupancy, out_RegWrite, out_WriteAddr, out_MEMOut} !==
        {1'b1, 1'b1, 2'd1, 1'b1, 5'd5, 32'hDEADBEEF})
      $display("FAIL basic_accept: v=%b f=%b occ=%0d rw=%b a=%0d d=%h, want 1 1 1 1 5 deadbeef",
               out_valid, fwd_valid, occupancy, out_RegWrite, out_WriteAddr, out_MEMOut);
    else n_pass++;
    cycle(0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] dv[3];
    for (int i = 0; i < 3; i++) dv[i] = $urandom;
    for (int i = 0; i < 3; i++) cycle(1, 1, 5'(i + 1), dv[i], 0, 0);
    n_chk++;
    if ({occupancy, in_ready, out_MEMOut} !== {2'd2, 1'b0, dv[0]})
      $display("FAIL bp_full: occ=%0d rdy=%b d=%h, want occ=2 rdy=0 d=%h",
               occupancy, in_ready, out_MEMOut, dv[0]);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (!out_valid || out_MEMOut !== dv[i])
        $display("FAIL bp_order%0d: v=%b d=%h, want v=1 d=%h", i, out_valid, out_MEMOut, dv[i]);
      else n_pass++;
      cycle(i < 2, 1, 5'd3, dv[2], 1, 0);
    end
    n_chk++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0)
      $display("FAIL bp_drain: v=%b occ=%0d, want 0 0", out_valid, occupancy);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int p0, bad;
    bad = 0;
    cycle(1, 1, 5'd7, $urandom, 1, 0);
    p0 = dut_pops;
    for (int i = 0; i < 10; i++) begin
      cycle(1, 1, 5'($urandom_range(1, 31)), $urandom, 1, 0);
      if (occupancy !== 2'd1 || {out_RegWrite, out_WriteAddr, out_MEMOut} !== exp_head()) bad++;
    end
    n_chk++;
    if (dut_pops - p0 !== 10 || bad != 0)
      $display("FAIL steady: pops=%0d bad_cycles=%0d, want pops=10 bad_cycles=0", dut_pops - p0, bad);
    else n_pass++;
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_zero_suppress();
    cycle(1, 1, 5'd0, 32'h1234_5678, 0, 0);
    n_chk++;
    if ({out_RegWrite, fwd_valid, out_WriteAddr, out_MEMOut} !== {1'b0, 1'b0, 5'd0, 32'h1234_5678})
      $display("FAIL zs_on: rw=%b f=%b a=%0d d=%h, want 0 0 0 12345678",
               out_RegWrite, fwd_valid, out_WriteAddr, out_MEMOut);
    else n_pass++;
    n_chk++;
    if ({rw0, fv0} !== 2'b11)
      $display("FAIL zs_off: rw=%b f=%b, want 1 1", rw0, fv0);
    else n_pass++;
    cycle(0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_flush();
    cycle(1, 1, 5'd9, $urandom, 0, 0);
    cycle(1, 1, 5'd10, $urandom, 0, 0);
    cycle(1, 1, 5'd11, 32'hF1F1F1F1, 0, 1);
    n_chk++;
    if ({out_valid, occupancy, in_ready} !== 4'b0001)
      $display("FAIL flush: v=%b occ=%0d rdy=%b, want v=0 occ=0 rdy=1", out_valid, occupancy, in_ready);
    else n_pass++;
    cycle(0, 0, 0, 0, 1, 0);
    n_chk++;
    if (out_valid !== 1'b0)
      $display("FAIL flush_lost: v=%b d=%h, want v=0", out_valid, out_MEMOut);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    cycle(1, 1, 5'd12, $urandom, 0, 0);
    cycle(1, 1, 5'd13, $urandom, 0, 0);
    rst = 1'b0;
    #1;
    q.delete(); mdl_rdy = 1'b0;
    n_chk++;
    if ({out_valid, occupancy, in_ready} !== 4'b0000)
      $display("FAIL reset_mid: v=%b occ=%0d rdy=%b, want 0 0 0", out_valid, occupancy, in_ready);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1;
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    int bad_st, bad_pl;
    bad_st = 0; bad_pl = 0;
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1), 5'($urandom_range(0, 31)),
            $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
      if ({out_valid, occupancy, in_ready, fwd_valid} !== exp_status()) begin
        if (bad_st == 0)
          $display("FAIL rand_status @%0d: got %b, want %b", i,
                   {out_valid, occupancy, in_ready, fwd_valid}, exp_status());
        bad_st++;
      end
      if (q.size() != 0 && {out_RegWrite, out_WriteAddr, out_MEMOut} !== exp_head()) begin
        if (bad_pl == 0)
          $display("FAIL rand_payload @%0d: got %h, want %h", i,
                   {out_RegWrite, out_WriteAddr, out_MEMOut}, exp_head());
        bad_pl++;
      end
    end
    n_chk++;
    if (bad_st == 0) n_pass++;
    n_chk++;
    if (bad_pl == 0) n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_zero_suppress();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
